// File: rtl/datapath_arbiter.sv
// datapath_arbiter: two-requester arbiter that latches one op word and drives the DataPath control bundle
module datapath_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int REG_W       = 4,
    parameter int ALUS_W      = 3,
    parameter int LOAD_CYCLES = 2,
    parameter int RR          = 1,
    localparam int OP_W       = 3 + ADDR_W + 3 * REG_W + ALUS_W
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              Req0,
    input  logic [OP_W-1:0]   Op0,
    input  logic              Req1,
    input  logic [OP_W-1:0]   Op1,
    output logic              Grant0,
    output logic              Grant1,
    output logic              Done0,
    output logic              Done1,
    output logic              Busy,
    output logic              D_Wr,
    output logic              RF_s,
    output logic              RF_W_en,
    output logic [ADDR_W-1:0] D_Addr,
    output logic [REG_W-1:0]  RF_W_Addr,
    output logic [REG_W-1:0]  RF_Ra_Addr,
    output logic [REG_W-1:0]  RF_Rb_Addr,
    output logic [ALUS_W-1:0] ALU_s
);
    localparam int CW = $clog2(LOAD_CYCLES + 1);
    localparam int WB = 3 * REG_W + ALUS_W;
    typedef enum logic {IDLE, EXEC} state_t;
    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [OP_W-1:0]   r_op;
    logic              r_who;
    logic              r_last;
    logic              w_pick1;
    logic [OP_W-1:0]   w_op;
    logic              w_load;
    logic              w_busy;
    logic              w_final;
    assign w_pick1 = Req1 & (!Req0 | ((RR != 0) & !r_last));
    assign w_op    = w_pick1 ? Op1 : Op0;
    assign w_load  = w_op[OP_W-2] & w_op[OP_W-3];
    assign w_busy  = r_state == EXEC;
    assign w_final = w_busy & (r_cnt == '0);
    // arbitrate in IDLE, latch the winning op, then count down its execution length
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_who   <= 1'b0;
            r_last  <= 1'b1;
        end else if (r_state == IDLE) begin
            if (Req0 | Req1) begin
                r_state <= EXEC;
                r_op    <= w_op;
                r_who   <= w_pick1;
                r_last  <= w_pick1;
                r_cnt   <= w_load ? CW'(LOAD_CYCLES - 1) : '0;
            end
        end else if (r_cnt == '0) begin
            r_state <= IDLE;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end
    // DataPath bundle is zero outside EXEC; write enables only fire in the last EXEC cycle
    always_comb begin
        Busy       = w_busy;
        Grant0     = w_busy & !r_who;
        Grant1     = w_busy & r_who;
        Done0      = w_final & !r_who;
        Done1      = w_final & r_who;
        D_Wr       = w_final & r_op[OP_W-1];
        RF_s       = w_busy & r_op[OP_W-2];
        RF_W_en    = w_final & r_op[OP_W-3];
        D_Addr     = w_busy ? r_op[OP_W-4 -: ADDR_W] : '0;
        RF_W_Addr  = w_busy ? r_op[WB-1 -: REG_W] : '0;
        RF_Ra_Addr = w_busy ? r_op[WB-REG_W-1 -: REG_W] : '0;
        RF_Rb_Addr = w_busy ? r_op[WB-2*REG_W-1 -: REG_W] : '0;
        ALU_s      = w_busy ? r_op[ALUS_W-1:0] : '0;
    end
endmodule

// File: tb/tb_datapath_arbiter.sv
// tb_datapath_arbiter: directed scenarios plus randomized run against a transaction-level model
module tb_datapath_arbiter;
    localparam int LC = 2;
    logic        Clk, ResetN, Req0, Req1;
    logic [25:0] Op0, Op1;
    logic        Grant0, Grant1, Done0, Done1, Busy, D_Wr, RF_s, RF_W_en;
    logic [7:0]  D_Addr;
    logic [3:0]  RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr;
    logic [2:0]  ALU_s;
    logic        f_Grant0, f_Grant1, f_Done0, f_Done1, f_Busy, f_D_Wr, f_RF_s, f_RF_W_en;
    logic [7:0]  f_D_Addr;
    logic [3:0]  f_RF_W_Addr, f_RF_Ra_Addr, f_RF_Rb_Addr;
    logic [2:0]  f_ALU_s;
    logic [30:0] obs, f_obs;
    int          checks, errors;

    datapath_arbiter #(.LOAD_CYCLES(LC), .RR(1)) dut (
        .Clk(Clk), .ResetN(ResetN), .Req0(Req0), .Op0(Op0), .Req1(Req1), .Op1(Op1),
        .Grant0(Grant0), .Grant1(Grant1), .Done0(Done0), .Done1(Done1), .Busy(Busy),
        .D_Wr(D_Wr), .RF_s(RF_s), .RF_W_en(RF_W_en), .D_Addr(D_Addr), .RF_W_Addr(RF_W_Addr),
        .RF_Ra_Addr(RF_Ra_Addr), .RF_Rb_Addr(RF_Rb_Addr), .ALU_s(ALU_s));

    datapath_arbiter #(.LOAD_CYCLES(LC), .RR(0)) dut_fp (
        .Clk(Clk), .ResetN(ResetN), .Req0(Req0), .Op0(Op0), .Req1(Req1), .Op1(Op1),
        .Grant0(f_Grant0), .Grant1(f_Grant1), .Done0(f_Done0), .Done1(f_Done1), .Busy(f_Busy),
        .D_Wr(f_D_Wr), .RF_s(f_RF_s), .RF_W_en(f_RF_W_en), .D_Addr(f_D_Addr), .RF_W_Addr(f_RF_W_Addr),
        .RF_Ra_Addr(f_RF_Ra_Addr), .RF_Rb_Addr(f_RF_Rb_Addr), .ALU_s(f_ALU_s));

    assign obs   = {Grant0, Grant1, Done0, Done1, Busy, D_Wr, RF_s, RF_W_en, D_Addr,
                    RF_W_Addr, RF_Ra_Addr, RF_Rb_Addr, ALU_s};
    assign f_obs = {f_Grant0, f_Grant1, f_Done0, f_Done1, f_Busy, f_D_Wr, f_RF_s, f_RF_W_en, f_D_Addr,
                    f_RF_W_Addr, f_RF_Ra_Addr, f_RF_Rb_Addr, f_ALU_s};

    always #5 Clk = ~Clk;

    function automatic logic [25:0] mk(input logic dwr, input logic rfs, input logic wen, input logic [7:0] addr,
                                       input logic [3:0] w, input logic [3:0] ra, input logic [3:0] rb,
                                       input logic [2:0] alu);
        return {dwr, rfs, wen, addr, w, ra, rb, alu};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        ResetN = 0;
        Req0 = 1;
        Req1 = 1;
        Op0 = mk(0, 0, 1, 8'h00, 4'd1, 4'd1, 4'd1, 3'd2);
        Op1 = mk(0, 0, 1, 8'h00, 4'd2, 4'd2, 4'd2, 3'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs !== 31'd0 || f_obs !== 31'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %h/%h, want 0", i, obs, f_obs);
            end
        end
        ResetN = 1;
        tick();
        checks++;
        if (obs[30:29] !== 2'b10 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_grant: grants %b busy %b, want 10 busy 1", obs[30:29], Busy);
        end
        Req0 = 0;
        Req1 = 0;
        tick();
        checks++;
        if (obs !== 31'd0) begin
            errors++;
            $display("FAIL reset_idle_after: got %h, want 0", obs);
        end
    endtask

    task automatic test_alu();
        Op0 = mk(0, 0, 1, 8'h00, 4'd4, 4'd2, 4'd3, 3'd1);
        Req0 = 1;
        tick();
        checks++;
        if (obs !== {5'b10101, mk(0, 0, 1, 8'h00, 4'd4, 4'd2, 4'd3, 3'd1)}) begin
            errors++;
            $display("FAIL alu_exec: got %h, want %h", obs, {5'b10101, mk(0, 0, 1, 8'h00, 4'd4, 4'd2, 4'd3, 3'd1)});
        end
        Req0 = 0;
        tick();
        checks++;
        if (obs !== 31'd0) begin
            errors++;
            $display("FAIL alu_idle: got %h, want 0", obs);
        end
    endtask

    task automatic test_load();
        Op1 = mk(0, 1, 1, 8'h1F, 4'd5, 4'd0, 4'd0, 3'd0);
        Req1 = 1;
        tick();
        checks++;
        if (obs !== {5'b01001, mk(0, 1, 0, 8'h1F, 4'd5, 4'd0, 4'd0, 3'd0)}) begin
            errors++;
            $display("FAIL load_cycle1: got %h, want %h", obs, {5'b01001, mk(0, 1, 0, 8'h1F, 4'd5, 4'd0, 4'd0, 3'd0)});
        end
        Op1 = 26'h3ABCDEF;
        tick();
        checks++;
        if (obs !== {5'b01011, mk(0, 1, 1, 8'h1F, 4'd5, 4'd0, 4'd0, 3'd0)}) begin
            errors++;
            $display("FAIL load_cycle2: got %h, want %h", obs, {5'b01011, mk(0, 1, 1, 8'h1F, 4'd5, 4'd0, 4'd0, 3'd0)});
        end
        Req1 = 0;
        tick();
        checks++;
        if (obs !== 31'd0) begin
            errors++;
            $display("FAIL load_idle: got %h, want 0", obs);
        end
    endtask

    task automatic test_store();
        Op1 = mk(1, 0, 0, 8'h40, 4'd0, 4'd7, 4'd0, 3'd0);
        Req1 = 1;
        tick();
        checks++;
        if (obs !== {5'b01011, mk(1, 0, 0, 8'h40, 4'd0, 4'd7, 4'd0, 3'd0)}) begin
            errors++;
            $display("FAIL store_exec: got %h, want %h", obs, {5'b01011, mk(1, 0, 0, 8'h40, 4'd0, 4'd7, 4'd0, 3'd0)});
        end
        Req1 = 0;
        tick();
        checks++;
        if (obs !== 31'd0) begin
            errors++;
            $display("FAIL store_idle: got %h, want 0", obs);
        end
    endtask

    task automatic test_back_to_back();
        Op0 = mk(0, 0, 1, 8'h00, 4'd1, 4'd2, 4'd3, 3'd4);
        Op1 = mk(0, 0, 1, 8'h00, 4'd6, 4'd5, 4'd4, 3'd5);
        Req0 = 1;
        Req1 = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (Busy !== 1'b1 || Grant1 !== 1'(i % 2) || Grant0 !== 1'(1 - i % 2)) begin
                errors++;
                $display("FAIL rr_grant op %0d: g0 %b g1 %b busy %b, want g1 %0d", i, Grant0, Grant1, Busy, i % 2);
            end
            checks++;
            if (f_Busy !== 1'b1 || f_Grant0 !== 1'b1 || f_Grant1 !== 1'b0) begin
                errors++;
                $display("FAIL fixed_grant op %0d: g0 %b g1 %b busy %b, want g0 1", i, f_Grant0, f_Grant1, f_Busy);
            end
            if (i == 3) begin
                Req0 = 0;
                Req1 = 0;
            end
            tick();
            checks++;
            if (Busy !== 1'b0 || f_Busy !== 1'b0) begin
                errors++;
                $display("FAIL bubble op %0d: busy %b/%b, want 0", i, Busy, f_Busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        Op1 = mk(0, 1, 1, 8'h1F, 4'd5, 4'd0, 4'd0, 3'd0);
        Req1 = 1;
        tick();
        checks++;
        if (Busy !== 1'b1 || Grant1 !== 1'b1) begin
            errors++;
            $display("FAIL midreset_start: busy %b g1 %b, want 1 1", Busy, Grant1);
        end
        ResetN = 0;
        #1;
        checks++;
        if (obs !== 31'd0) begin
            errors++;
            $display("FAIL midreset_async: got %h, want 0", obs);
        end
        Req1 = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (obs !== 31'd0) begin
                errors++;
                $display("FAIL midreset_hold cycle %0d: got %h, want 0", i, obs);
            end
        end
        ResetN = 1;
        tick();
        checks++;
        if (obs !== 31'd0) begin
            errors++;
            $display("FAIL midreset_release: got %h, want 0", obs);
        end
    endtask

    task automatic test_drop_mid();
        Op0 = mk(0, 1, 1, 8'h22, 4'd3, 4'd0, 4'd0, 3'd0);
        Req0 = 1;
        tick();
        checks++;
        if (Grant0 !== 1'b1 || Done0 !== 1'b0) begin
            errors++;
            $display("FAIL drop_cycle1: g0 %b d0 %b, want 1 0", Grant0, Done0);
        end
        Req0 = 0;
        tick();
        checks++;
        if (obs !== {5'b10101, mk(0, 1, 1, 8'h22, 4'd3, 4'd0, 4'd0, 3'd0)}) begin
            errors++;
            $display("FAIL drop_cycle2: got %h, want %h", obs, {5'b10101, mk(0, 1, 1, 8'h22, 4'd3, 4'd0, 4'd0, 3'd0)});
        end
        tick();
        checks++;
        if (obs !== 31'd0) begin
            errors++;
            $display("FAIL drop_idle: got %h, want 0", obs);
        end
    endtask

    function automatic logic [25:0] rand_op();
        logic [25:0] o;
        o = 26'($urandom());
        if ($urandom_range(0, 1) == 1) o[24:23] = 2'b11;
        return o;
    endfunction

    // model: each instance holds the remaining EXEC cycles of its current op (0 = idle)
    task automatic test_random();
        int          m_left[2];
        logic        m_who[2], m_last[2];
        logic [25:0] m_op[2];
        logic        p, bz, fn;
        logic [30:0] e;
        ResetN = 0;
        Req0 = 0;
        Req1 = 0;
        tick();
        ResetN = 1;
        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0;
            m_last[k] = 1;
            m_who[k] = 0;
            m_op[k] = '0;
        end
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (m_left[k] > 0) m_left[k]--;
                else if (Req0 || Req1) begin
                    p = Req1 && (!Req0 || (k == 0 && !m_last[k]));
                    m_who[k] = p;
                    m_last[k] = p;
                    m_op[k] = p ? Op1 : Op0;
                    m_left[k] = (m_op[k][24] && m_op[k][23]) ? LC : 1;
                end
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                bz = m_left[k] > 0;
                fn = m_left[k] == 1;
                e = {bz && !m_who[k], bz && m_who[k], fn && !m_who[k], fn && m_who[k], bz,
                     bz ? {m_op[k][25] & fn, m_op[k][24], m_op[k][23] & fn, m_op[k][22:0]} : 26'd0};
                checks++;
                if ((k == 0 ? obs : f_obs) !== e) begin
                    errors++;
                    $display("FAIL random rr=%0d cycle %0d: got %h, want %h", 1 - k, c, k == 0 ? obs : f_obs, e);
                end
            end
            if (Done0) Req0 = 0;
            else if (!Req0 && $urandom_range(0, 2) == 0) begin
                Req0 = 1;
                Op0 = rand_op();
            end else if (Req0 && Grant0) begin
                Op0 = rand_op();
                if ($urandom_range(0, 3) == 0) Req0 = 0;
            end
            if (Done1) Req1 = 0;
            else if (!Req1 && $urandom_range(0, 2) == 0) begin
                Req1 = 1;
                Op1 = rand_op();
            end else if (Req1 && Grant1) begin
                Op1 = rand_op();
                if ($urandom_range(0, 3) == 0) Req1 = 0;
            end
        end
    endtask

    initial begin
        Clk = 0;
        ResetN = 0;
        Req0 = 0;
        Req1 = 0;
        Op0 = '0;
        Op1 = '0;
        checks = 0;
        errors = 0;
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_back_to_back();
        test_reset_mid();
        test_drop_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
